// File: rtl/ov7725_frame_crop.sv
//==============================================================================
// Module   : ov7725_frame_crop
// Purpose  : Tracks the x/y position of every RGB565 pixel coming out of the
//            OV7725 pixel-assembly stage and forwards only the pixels that
//            fall inside a fixed rectangular window to the write-FIFO.
//            Reports frame start, frame completion and short (truncated)
//            frames.
// Options  : CROP_DECIMATE_EN - when defined, 2:1 decimation in both axes
//            inside the window (only even relative column/line is output,
//            pix_x/pix_y are the halved relative coordinates).
// Ports    : ov7725_pclk     in   camera pixel clock (sole clock)
//            sys_rst_n       in   asynchronous active-low reset
//            ov7725_vsync    in   field sync, rising edge = frame boundary
//            ov7725_wr_en    in   input pixel strobe (one cycle per pixel)
//            ov7725_data_in  in   input RGB565 pixel
//            crop_en         in   capture enable (level)
//            crop_wr_en      out  output pixel valid (FIFO write enable)
//            crop_data       out  output pixel
//            pix_x           out  window-relative column of crop_data
//            pix_y           out  window-relative line of crop_data
//            frame_start     out  one-cycle pulse at start of a frame
//            frame_done      out  one-cycle pulse after a complete frame
//            frame_err       out  sticky short-frame flag
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ov7725_frame_crop #(
  parameter int H_PIXEL = 640,
  parameter int V_PIXEL = 480,
  parameter int CROP_X0 = 160,
  parameter int CROP_Y0 = 120,
  parameter int CROP_W  = 320,
  parameter int CROP_H  = 240
) (
  input  logic        ov7725_pclk,
  input  logic        sys_rst_n,
  input  logic        ov7725_vsync,
  input  logic        ov7725_wr_en,
  input  logic [15:0] ov7725_data_in,
  input  logic        crop_en,
  output logic        crop_wr_en,
  output logic [15:0] crop_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [9:0] c_X_MAX = 10'(H_PIXEL - 1);
  localparam logic [8:0] c_Y_MAX = 9'(V_PIXEL - 1);
  localparam logic [9:0] c_X0    = 10'(CROP_X0);
  localparam logic [9:0] c_X1    = 10'(CROP_X0 + CROP_W);
  localparam logic [8:0] c_Y0    = 9'(CROP_Y0);
  localparam logic [8:0] c_Y1    = 9'(CROP_Y0 + CROP_H);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_vsync_dly;
  logic        w_vs_rise;

  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic        w_line_end;
  logic        w_frame_last;

  // Set when the final pixel and a new vsync edge land together, so that
  // DONE can hand over straight to ACTIVE without waiting for another edge.
  logic        r_pend;
  logic        w_pend_nxt;

  logic        w_cnt_clr;
  logic        w_cnt_step;
  logic        w_start_nxt;
  logic        w_done_nxt;
  logic        w_err_set;
  logic        w_err_clr;

  logic        w_in_win;
  logic [9:0]  w_rel_x;
  logic [8:0]  w_rel_y;
  logic        w_keep;
  logic [9:0]  w_out_x;
  logic [8:0]  w_out_y;
  logic        w_accept;

  //--------------------------------------------------------------------------
  // Sync edge detection
  //--------------------------------------------------------------------------
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vsync_dly <= 1'b0;
    end else begin
      r_vsync_dly <= ov7725_vsync;
    end
  end

  assign w_vs_rise    = ov7725_vsync & ~r_vsync_dly;
  assign w_line_end   = (r_x == c_X_MAX);
  assign w_frame_last = w_line_end & (r_y == c_Y_MAX);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and control decode
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_step  = 1'b0;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (crop_en) begin
          w_state_nxt = ST_SYNC;
        end else begin
          w_err_clr = 1'b1;
        end
      end

      ST_SYNC: begin
        if (!crop_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vs_rise) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_clr   = 1'b1;
          w_start_nxt = 1'b1;
        end
      end

      ST_ACTIVE: begin
        // The final pixel wins over a coincident vsync edge: the frame is
        // complete and the new one is entered via DONE.
        if (ov7725_wr_en && w_frame_last) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_pend_nxt  = w_vs_rise;
        end else if (w_vs_rise) begin
          w_err_set   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_start_nxt = 1'b1;
        end else if (ov7725_wr_en) begin
          w_cnt_step  = 1'b1;
        end
      end

      ST_DONE: begin
        if (r_pend && crop_en) begin
          w_state_nxt = ST_ACTIVE;
          w_start_nxt = 1'b1;
        end else if (crop_en) begin
          w_state_nxt = ST_SYNC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Position counters (wrap exactly at the frame edges)
  //--------------------------------------------------------------------------
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_cnt_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_cnt_step) begin
      if (w_line_end) begin
        r_x <= '0;
        r_y <= r_y + 9'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Window test on the pre-increment position of the current pixel
  //--------------------------------------------------------------------------
  assign w_in_win = (r_x >= c_X0) && (r_x < c_X1) &&
                    (r_y >= c_Y0) && (r_y < c_Y1);
  assign w_rel_x  = r_x - c_X0;
  assign w_rel_y  = r_y - c_Y0;

`ifdef CROP_DECIMATE_EN
  assign w_keep  = ~w_rel_x[0] & ~w_rel_y[0];
  assign w_out_x = {1'b0, w_rel_x[9:1]};
  assign w_out_y = {1'b0, w_rel_y[8:1]};
`else
  assign w_keep  = 1'b1;
  assign w_out_x = w_rel_x;
  assign w_out_y = w_rel_y;
`endif

  assign w_accept = ov7725_wr_en & (r_state == ST_ACTIVE) & w_in_win & w_keep;

  //--------------------------------------------------------------------------
  // Output pipeline: data/position hold while crop_wr_en is low
  //--------------------------------------------------------------------------
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crop_wr_en <= 1'b0;
      crop_data  <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
    end else begin
      crop_wr_en <= w_accept;
      if (w_accept) begin
        crop_data <= ov7725_data_in;
        pix_x     <= w_out_x;
        pix_y     <= w_out_y;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Frame status
  //--------------------------------------------------------------------------
  always_ff @(posedge ov7725_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_start <= w_start_nxt;
      frame_done  <= w_done_nxt;
      if (w_err_set) begin
        frame_err <= 1'b1;
      end else if (w_err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
